// File: rtl/xmit_priority_sched.sv
// Strict-priority frame scheduler with lo starvation guard, illegal-length drop and fixed IFG.
// Latency: ctrl_rd in N, first byte N+2; backpressure: tx_byte_rdy low holds the byte, drops ignore it.
module xmit_priority_sched #(
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int IFG_CYCLES = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hi_ctrl_valid,
  input  logic [23:0] hi_ctrl_in,
  output logic        hi_ctrl_rd,
  input  logic [7:0]  hi_data_in,
  output logic        hi_data_rd,
  input  logic        lo_ctrl_valid,
  input  logic [23:0] lo_ctrl_in,
  output logic        lo_ctrl_rd,
  input  logic [7:0]  lo_data_in,
  output logic        lo_data_rd,
  input  logic        tx_byte_rdy,
  output logic        tx_byte_valid,
  output logic [7:0]  tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [11:0] tx_tag,
  output logic        discard_en,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LOAD, XMIT, DROP, GAP} state_t;

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [GW-1:0] IFG_LAST   = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t        state, state_nx;
  logic [11:0]   len_q, tag_q, byte_cnt;
  logic          sel_lo, first_q, data_rd;
  logic [SW-1:0] streak;
  logic [GW-1:0] ifg_cnt;
  logic          grant_any, grant_lo, len_bad, last_byte;

  assign grant_any = hi_ctrl_valid | lo_ctrl_valid;
  assign grant_lo  = lo_ctrl_valid & (~hi_ctrl_valid | (streak == STREAK_MAX));
  assign len_bad   = (len_q < 12'(MIN_LEN)) | (len_q > 12'(MAX_LEN));
  assign last_byte = (byte_cnt == 12'd1);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx      = state;
    hi_ctrl_rd    = 1'b0;
    lo_ctrl_rd    = 1'b0;
    data_rd       = 1'b0;
    tx_byte_valid = 1'b0;
    tx_data       = 8'h00;
    tx_sof        = 1'b0;
    tx_eof        = 1'b0;
    case (state)
      IDLE: begin
        // Gated by the reset pin so no pop can escape while reset is held.
        if (grant_any && reset) begin
          hi_ctrl_rd = ~grant_lo;
          lo_ctrl_rd = grant_lo;
          state_nx   = LOAD;
        end
      end
      LOAD: begin
        if (!len_bad)           state_nx = XMIT;
        else if (len_q == '0)   state_nx = AFTER_FRAME;
        else                    state_nx = DROP;
      end
      XMIT: begin
        tx_byte_valid = 1'b1;
        tx_data       = sel_lo ? lo_data_in : hi_data_in;
        tx_sof        = first_q;
        tx_eof        = last_byte;
        data_rd       = tx_byte_rdy;
        if (tx_byte_rdy && last_byte) state_nx = AFTER_FRAME;
      end
      DROP: begin
        data_rd = 1'b1;
        if (last_byte) state_nx = AFTER_FRAME;
      end
      GAP: begin
        if (ifg_cnt == IFG_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hi_data_rd = data_rd & ~sel_lo;
  assign lo_data_rd = data_rd & sel_lo;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_q      <= '0;
      tag_q      <= '0;
      byte_cnt   <= '0;
      sel_lo     <= 1'b0;
      first_q    <= 1'b0;
      streak     <= '0;
      ifg_cnt    <= '0;
      tx_tag     <= '0;
      discard_en <= 1'b0;
    end else begin
      state      <= state_nx;
      discard_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            len_q  <= grant_lo ? lo_ctrl_in[11:0]  : hi_ctrl_in[11:0];
            tag_q  <= grant_lo ? lo_ctrl_in[23:12] : hi_ctrl_in[23:12];
            sel_lo <= grant_lo;
            // Streak only grows while lo is actually being held off.
            if (grant_lo || !lo_ctrl_valid) streak <= '0;
            else if (streak != STREAK_MAX)  streak <= streak + 1'b1;
          end
        end
        LOAD: begin
          byte_cnt <= len_q;
          tx_tag   <= tag_q;
          first_q  <= 1'b1;
          if (len_q == '0) discard_en <= 1'b1;
        end
        XMIT: begin
          if (tx_byte_rdy) begin
            byte_cnt <= byte_cnt - 1'b1;
            first_q  <= 1'b0;
          end
        end
        DROP: begin
          byte_cnt <= byte_cnt - 1'b1;
          if (last_byte) discard_en <= 1'b1;
        end
        GAP: begin
          ifg_cnt <= (ifg_cnt == IFG_LAST) ? '0 : ifg_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xmit_priority_sched.sv
// Scoreboard bench for xmit_priority_sched: queue models feed the DUT, a monitor checks every output byte.
module tb_xmit_priority_sched;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        hi_ctrl_valid, lo_ctrl_valid;
  logic [23:0] hi_ctrl_in, lo_ctrl_in;
  logic        hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd;
  logic [7:0]  hi_data_in, lo_data_in, tx_data;
  logic        tx_byte_rdy, tx_byte_valid, tx_sof, tx_eof, discard_en, busy;
  logic [11:0] tx_tag;

  typedef struct packed {
    logic [7:0]  dat;
    logic        sof;
    logic        eof;
    logic [11:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] disc_q[$];
  logic [23:0] hc_q[$], lc_q[$];
  logic [7:0]  hd_q[$], ld_q[$];
  logic [7:0]  gr_q[$];
  logic [7:0]  gexp[10];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int hi_pops = 0, lo_pops = 0, disc_cnt = 0;
  int last_eof = -1, rd_cyc = -1;
  bit chk_gap = 0, chk_ifg = 0, lat_arm = 0, stall_mode = 0;
  bit prev_stall = 0;
  logic [9:0] prev_out;

  always #5 clk_sys = ~clk_sys;

  xmit_priority_sched dut (
    .clk_sys(clk_sys), .reset(reset),
    .hi_ctrl_valid(hi_ctrl_valid), .hi_ctrl_in(hi_ctrl_in), .hi_ctrl_rd(hi_ctrl_rd),
    .hi_data_in(hi_data_in), .hi_data_rd(hi_data_rd),
    .lo_ctrl_valid(lo_ctrl_valid), .lo_ctrl_in(lo_ctrl_in), .lo_ctrl_rd(lo_ctrl_rd),
    .lo_data_in(lo_data_in), .lo_data_rd(lo_data_rd),
    .tx_byte_rdy(tx_byte_rdy), .tx_byte_valid(tx_byte_valid), .tx_data(tx_data),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_tag(tx_tag),
    .discard_en(discard_en), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [11:0] tag, input int k);
    return tag[7:0] ^ k[7:0];
  endfunction

  task automatic drive_inputs();
    hi_ctrl_valid = (hc_q.size() > 0);
    hi_ctrl_in    = hi_ctrl_valid ? hc_q[0] : 24'h0;
    hi_data_in    = (hd_q.size() > 0) ? hd_q[0] : 8'h00;
    lo_ctrl_valid = (lc_q.size() > 0);
    lo_ctrl_in    = lo_ctrl_valid ? lc_q[0] : 24'h0;
    lo_data_in    = (ld_q.size() > 0) ? ld_q[0] : 8'h00;
  endtask

  task automatic push_q(input bit lo, input logic [11:0] tag, input logic [11:0] len);
    for (int k = 0; k < int'(len); k++) begin
      if (lo) ld_q.push_back(byte_of(tag, k));
      else    hd_q.push_back(byte_of(tag, k));
    end
    if (lo) lc_q.push_back({tag, len});
    else    hc_q.push_back({tag, len});
    drive_inputs();
  endtask

  task automatic push_exp(input logic [11:0] tag, input logic [11:0] len, input bit xmit);
    exp_t e;
    if (!xmit) disc_q.push_back(tag);
    else
      for (int k = 0; k < int'(len); k++) begin
        e.dat = byte_of(tag, k);
        e.sof = (k == 0);
        e.eof = (k == int'(len) - 1);
        e.tag = tag;
        exp_q.push_back(e);
      end
  endtask

  task automatic sync();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || disc_q.size() != 0 || hc_q.size() != 0 ||
            lc_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk_sys);
      #2;
      n++;
    end
    n_chk++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes and %0d discards outstanding after %0d cycles",
               name, exp_q.size(), disc_q.size(), budget);
    end
  endtask

  // Queue models: sample pops at negedge, apply them just after the next rising edge.
  initial begin
    bit s_hcr, s_lcr, s_hdr, s_ldr;
    forever begin
      @(negedge clk_sys);
      s_hcr = hi_ctrl_rd; s_lcr = lo_ctrl_rd; s_hdr = hi_data_rd; s_ldr = lo_data_rd;
      if (s_hcr || s_lcr) check("ctrl_rd_exclusive", {s_hcr, s_lcr} == 2'b11, 0);
      if (s_hdr || s_ldr) check("data_rd_exclusive", {s_hdr, s_ldr} == 2'b11, 0);
      @(posedge clk_sys);
      #1;
      if (s_hcr) begin gr_q.push_back("H"); if (hc_q.size() > 0) void'(hc_q.pop_front()); end
      if (s_lcr) begin gr_q.push_back("L"); if (lc_q.size() > 0) void'(lc_q.pop_front()); end
      if (s_hdr) begin hi_pops++; if (hd_q.size() > 0) void'(hd_q.pop_front()); end
      if (s_ldr) begin lo_pops++; if (ld_q.size() > 0) void'(ld_q.pop_front()); end
      if (stall_mode) tx_byte_rdy = ~tx_byte_rdy;
      drive_inputs();
    end
  end

  // Monitor: compares DUT output against the scoreboard queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!reset) begin
        prev_stall = 0;
        continue;
      end
      if (lat_arm && (hi_ctrl_rd || lo_ctrl_rd)) rd_cyc = cyc;
      if (tx_byte_valid) begin
        if (lat_arm && rd_cyc >= 0) begin
          check("first_byte_latency", cyc - rd_cyc, 2);
          lat_arm = 0;
          rd_cyc  = -1;
        end
        if (prev_stall) check("stall_hold", {tx_data, tx_sof, tx_eof}, prev_out);
        if (exp_q.size() == 0) begin
          check("spurious_valid", tx_byte_valid, 0);
        end else if (tx_byte_rdy) begin
          e = exp_q.pop_front();
          check("tx_byte", {tx_data, tx_sof, tx_eof, tx_tag}, e);
          if (tx_sof && chk_gap && last_eof >= 0) check("ifg_gap", cyc - last_eof - 1, 14);
          if (tx_eof) last_eof = cyc;
        end
        prev_stall = !tx_byte_rdy;
        prev_out   = {tx_data, tx_sof, tx_eof};
      end else begin
        prev_stall = 0;
      end
      if (chk_ifg && last_eof >= 0) begin
        if (cyc == last_eof + 12) check("gap_busy", busy, 1);
        if (cyc == last_eof + 13) begin
          check("gap_end_idle", busy, 0);
          chk_ifg = 0;
        end
      end
      if (discard_en) begin
        disc_cnt++;
        if (disc_q.size() == 0) check("spurious_discard", discard_en, 0);
        else check("discard_tag", tx_tag, disc_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    tx_byte_rdy = 1'b0;
    drive_inputs();
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs", {hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, tx_byte_valid,
                            tx_data, tx_sof, tx_eof, tx_tag, discard_en, busy}, 0);
    @(negedge clk_sys);
    reset = 1'b1;
    tx_byte_rdy = 1'b1;
    sync();

    // Single 64-byte hi frame, tag 040, then the 12-cycle gap.
    hi_pops = 0; lat_arm = 1; chk_ifg = 1; last_eof = -1;
    push_q(0, 12'h040, 12'h040);
    push_exp(12'h040, 12'h040, 1);
    wait_done("single", 400);
    check("single_tag", tx_tag, 12'h040);
    check("single_pops", hi_pops, 64);

    // Both queues loaded: grant order H,H,H,H,L,H,H,H,H,L with 14 idle cycles between frames.
    gr_q.delete(); chk_gap = 1; last_eof = -1; hi_pops = 0; lo_pops = 0;
    for (int i = 0; i < 8; i++) push_q(0, 12'h100 + 12'(i), 12'd64);
    for (int j = 0; j < 2; j++) push_q(1, 12'h200 + 12'(j), 12'd64);
    for (int i = 0; i < 4; i++) push_exp(12'h100 + 12'(i), 12'd64, 1);
    push_exp(12'h200, 12'd64, 1);
    for (int i = 4; i < 8; i++) push_exp(12'h100 + 12'(i), 12'd64, 1);
    push_exp(12'h201, 12'd64, 1);
    for (int i = 0; i < 10; i++) gexp[i] = (i == 4 || i == 9) ? "L" : "H";
    wait_done("grant", 2000);
    chk_gap = 0;
    check("grant_count", gr_q.size(), 10);
    for (int i = 0; i < 10 && i < gr_q.size(); i++) check($sformatf("grant_%0d", i), gr_q[i], gexp[i]);
    check("grant_lo_pops", lo_pops, 128);

    // Runt frame: 32 pops, no valid, one discard.
    hi_pops = 0; disc_cnt = 0;
    push_q(0, 12'h0A1, 12'h020);
    push_exp(12'h0A1, 12'h020, 0);
    wait_done("runt", 300);
    check("runt_pops", hi_pops, 32);
    check("runt_discards", disc_cnt, 1);

    // Serializer ready toggling each cycle.
    hi_pops = 0; stall_mode = 1;
    push_q(0, 12'h0B2, 12'd64);
    push_exp(12'h0B2, 12'd64, 1);
    wait_done("stall", 600);
    stall_mode = 0; tx_byte_rdy = 1'b1;
    check("stall_pops", hi_pops, 64);

    // Reset mid-frame after 30 bytes.
    hi_pops = 0;
    push_q(0, 12'h0C3, 12'd64);
    push_exp(12'h0C3, 12'd64, 1);
    n = 0;
    while (hi_pops < 30 && n < 300) begin sync(); n++; end
    if (n >= 300) check("midreset_reach", hi_pops, 30);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_outputs", {hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, tx_byte_valid,
                               tx_data, tx_sof, tx_eof, tx_tag, discard_en, busy}, 0);
    exp_q.delete(); hc_q.delete(); hd_q.delete();
    drive_inputs();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    sync();
    hi_pops = 0; lat_arm = 1;
    push_q(0, 12'h0C4, 12'd64);
    push_exp(12'h0C4, 12'd64, 1);
    wait_done("postreset", 400);
    check("postreset_pops", hi_pops, 64);
    check("postreset_tag", tx_tag, 12'h0C4);

    // Length boundaries: 0 and 1519 dropped, 1518 sent.
    hi_pops = 0; disc_cnt = 0;
    push_q(0, 12'h0D0, 12'd0);    push_exp(12'h0D0, 12'd0, 0);
    push_q(0, 12'h0D1, 12'h5EF);  push_exp(12'h0D1, 12'h5EF, 0);
    push_q(0, 12'h0D2, 12'h5EE);  push_exp(12'h0D2, 12'h5EE, 1);
    wait_done("bounds", 8000);
    check("bounds_discards", disc_cnt, 2);
    check("bounds_pops", hi_pops, 3037);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
